// File: rtl/ptr_sync_status_block.sv
// Write-side read-pointer synchronizer for an asynchronous FIFO.
// Brings the Gray read pointer across and derives registered fill status.
module ptr_sync_status_block #(
    parameter int addr_size         = 3,
    parameter int sync_stages       = 2,
    parameter int almost_full_level = 2
) (
    input  logic                 write_clock_i,
    input  logic                 write_reset_i,
    input  logic [addr_size:0]   read_pointer_i,
    input  logic [addr_size:0]   write_pointer_bin_i,
    output logic [addr_size:0]   read_to_write_pointer_o,
    output logic [addr_size:0]   read_to_write_pointer_bin_o,
    output logic                 full_o,
    output logic                 almost_full_o,
    output logic [addr_size:0]   free_count_o,
    output logic                 pointer_update_o,
    output logic                 gray_error_o
);

    localparam int PW = addr_size + 1;
    localparam logic [PW-1:0] DEPTH  = {1'b1, {addr_size{1'b0}}};
    localparam logic [PW-1:0] LEVEL  = PW'(almost_full_level);
    localparam logic          AF_RST = (DEPTH <= LEVEL);

    logic [PW-1:0] sync_q [0:sync_stages-1];
    logic [PW-1:0] last;

    logic [PW-1:0] rbin_d, rbin_q;
    logic [PW-1:0] used_d;
    logic [PW-1:0] free_d, free_q;
    logic [PW-1:0] diff_d;
    logic [PW-1:0] prev_q;
    logic          full_d, full_q;
    logic          af_d, af_q;
    logic          upd_d, upd_q;
    logic          err_d, err_q;

    always_ff @(posedge write_clock_i or posedge write_reset_i) begin
        if (write_reset_i) begin
            for (int i = 0; i < sync_stages; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= read_pointer_i;
            for (int i = 1; i < sync_stages; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign last = sync_q[sync_stages-1];

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        rbin_d = '0;
        for (int i = 0; i < PW; i++) begin
            rbin_d[i] = ^(last >> i);
        end
    end

    always_comb begin
        used_d = write_pointer_bin_i - rbin_d;
        free_d = DEPTH - used_d;
        full_d = (write_pointer_bin_i[addr_size] != rbin_d[addr_size]) &&
                 (write_pointer_bin_i[addr_size-1:0] == rbin_d[addr_size-1:0]);
        af_d   = (free_d <= LEVEL);
        diff_d = last ^ prev_q;
        upd_d  = |diff_d;
        // More than one bit set means the clear-lowest-bit result is nonzero.
        err_d  = err_q | (|(diff_d & (diff_d - PW'(1)))) | (used_d > DEPTH);
    end

    always_ff @(posedge write_clock_i or posedge write_reset_i) begin
        if (write_reset_i) begin
            rbin_q <= '0;
            free_q <= DEPTH;
            full_q <= 1'b0;
            af_q   <= AF_RST;
            prev_q <= '0;
            upd_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            rbin_q <= rbin_d;
            free_q <= free_d;
            full_q <= full_d;
            af_q   <= af_d;
            prev_q <= last;
            upd_q  <= upd_d;
            err_q  <= err_d;
        end
    end

    assign read_to_write_pointer_o     = last;
    assign read_to_write_pointer_bin_o = rbin_q;
    assign free_count_o                = free_q;
    assign full_o                      = full_q;
    assign almost_full_o               = af_q;
    assign pointer_update_o            = upd_q;
    assign gray_error_o                = err_q;

endmodule
